// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM access arbiter: access-phase state
// encoding, default SRAM window and bank/word-address geometry.
package sram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } arb_state_e;

    localparam logic [15:0] SRAM_BASE_HI_DEFAULT = 16'h2000;
    localparam int          BANK_BIT             = 15;
    localparam int          MEM_AW               = 15;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sram_access_arbiter_rr_arb2.sv
// Two-port arbiter: round-robin by default, fixed priority to port 0 when
// SRAM_ARB_FIXED_PRIO_EN is defined (pointer removed, port 1 may starve).
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       ptr
);

`ifdef SRAM_ARB_FIXED_PRIO_EN
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset, advance};
    assign ptr           = 1'b0;

    always_comb begin
        gnt = 2'b00;
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end
`else
    // ptr_q names the port favoured on the next simultaneous request.
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt   = req;
        ptr_d = ptr_q;
        if (req == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end
        if (advance) begin
            ptr_d = gnt[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`endif

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares two external SRAM banks between the CPU LSU (port 0) and UART RX DMA
// (port 1); optional macro SRAM_ARB_FIXED_PRIO_EN selects fixed priority.
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter logic [15:0] SRAM_BASE_HI = SRAM_BASE_HI_DEFAULT,
    parameter int          SETUP_CYC    = 1,
    parameter int          STROBE_CYC   = 2,
    parameter int          HOLD_CYC     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [15:0] rdata,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        CE0,
    output logic        CE1,
    output logic        OE0,
    output logic        OE1,
    output logic        WE0,
    output logic        WE1
);

    localparam int CNT_W = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'((STROBE_CYC > 0) ? STROBE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic              bank_q, bank_d;
    logic              miss_q, miss_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic [15:0]       rdata_q, rdata_d;
    logic [1:0]        ce_n_q, ce_n_d;
    logic [1:0]        oe_n_q, oe_n_d;
    logic [1:0]        we_n_q, we_n_d;
    logic [1:0]        ack_q, ack_d;
    logic [1:0]        err_q, err_d;

    logic [1:0]        gnt;
    logic              arb_advance;
    logic              arb_ptr;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [15:0]       sel_wdata;
    logic              sel_miss;
    logic              active_d;
    logic              strobe_d;
    logic              done_d;
    logic              unused_bits;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     ({req1, req0}),
        .advance (arb_advance),
        .gnt     (gnt),
        .ptr     (arb_ptr)
    );

    assign sel_we      = gnt[1] ? we1 : we0;
    assign sel_addr    = gnt[1] ? addr1 : addr0;
    assign sel_wdata   = gnt[1] ? wdata1 : wdata0;
    assign sel_miss    = (sel_addr[31:16] != SRAM_BASE_HI);
    assign unused_bits = ^{sel_addr[0], arb_ptr};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        port_d      = port_q;
        we_d        = we_q;
        bank_d      = bank_q;
        miss_d      = miss_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        arb_advance = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    arb_advance = 1'b1;
                    port_d      = gnt[1];
                    we_d        = sel_we;
                    bank_d      = sel_addr[BANK_BIT];
                    miss_d      = sel_miss;
                    cnt_d       = '0;
                    if (sel_miss) begin
                        state_d = DONE;
                    end else begin
                        mem_addr_d = sel_addr[MEM_AW:1];
                        if (sel_we) begin
                            mem_wdata_d = sel_wdata;
                        end
                        if (SETUP_CYC > 0) begin
                            state_d = SETUP;
                        end else begin
                            state_d = STROBE;
                        end
                    end
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = STROBE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    cnt_d = '0;
                    if (HOLD_CYC > 0) begin
                        state_d = HOLD;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pin strobes are registered from the next state so they line up with the phase.
    assign active_d = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    assign strobe_d = (state_d == STROBE);
    assign done_d   = (state_d == DONE);

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        localparam logic SEL = 1'(gi);
        assign ce_n_d[gi] = ~(active_d & (bank_d == SEL));
        assign oe_n_d[gi] = ~(strobe_d & ~we_d & (bank_d == SEL));
        assign we_n_d[gi] = ~(strobe_d & we_d & (bank_d == SEL));
        assign ack_d[gi]  = done_d & (port_d == SEL);
        assign err_d[gi]  = done_d & (port_d == SEL) & miss_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            bank_q      <= 1'b0;
            miss_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            ce_n_q      <= 2'b11;
            oe_n_q      <= 2'b11;
            we_n_q      <= 2'b11;
            ack_q       <= 2'b00;
            err_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            port_q      <= port_d;
            we_q        <= we_d;
            bank_q      <= bank_d;
            miss_q      <= miss_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

    assign ack0      = ack_q[0];
    assign ack1      = ack_q[1];
    assign err0      = err_q[0];
    assign err1      = err_q[1];
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign CE0       = ce_n_q[0];
    assign CE1       = ce_n_q[1];
    assign OE0       = oe_n_q[0];
    assign OE1       = oe_n_q[1];
    assign WE0       = we_n_q[0];
    assign WE1       = we_n_q[1];

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: transaction-level timeline model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_sram_access_arbiter;

    localparam int S = 1;
    localparam int T = 2;
    localparam int H = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [15:0] rdata;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        CE0, CE1, OE0, OE1, WE0, WE1;

    sram_access_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .CE0(CE0), .CE1(CE1), .OE0(OE0), .OE1(OE1), .WE0(WE0), .WE1(WE1)
    );

    // Second instance with the shortest legal access timing.
    logic        f_req0, f_we0;
    logic [31:0] f_addr0;
    logic        f_ack0, f_ack1, f_err0, f_err1;
    logic [15:0] f_rdata, f_mem_wdata, f_mem_rdata;
    logic [14:0] f_mem_addr;
    logic        f_CE0, f_CE1, f_OE0, f_OE1, f_WE0, f_WE1;

    sram_access_arbiter #(.SETUP_CYC(0), .STROBE_CYC(1), .HOLD_CYC(0)) dut_fast (
        .clk(clk), .reset(reset),
        .req0(f_req0), .req1(1'b0), .we0(f_we0), .we1(1'b0),
        .addr0(f_addr0), .addr1(32'h0), .wdata0(16'h0), .wdata1(16'h0),
        .ack0(f_ack0), .ack1(f_ack1), .err0(f_err0), .err1(f_err1),
        .rdata(f_rdata), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata),
        .CE0(f_CE0), .CE1(f_CE1), .OE0(f_OE0), .OE1(f_OE1), .WE0(f_WE0), .WE1(f_WE1)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic        req_v[2], we_v[2], inflight[2];
    logic [31:0] addr_v[2];
    logic [15:0] wdata_v[2];
    int          dcnt[2];
    logic        rand_mode, rst_v;
    logic [15:0] d_rdata;

    // Model: current access described by its offset from the arbitration cycle.
    logic        m_busy, m_port, m_we, m_miss, m_bank, m_fav;
    int          m_k, m_len, t_grant;
    logic [31:0] m_addr;
    logic [15:0] m_wdata, m_rdata;
    logic [1:0]  exp_ack;

    int          ob_ce_low[2], ob_oe_low[2], ob_we_low[2], ob_ack_cyc[2];
    logic        ob_err[2];
    logic [15:0] ob_rdata, ob_wdata;
    logic [14:0] ob_waddr;
    int          ack_order[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_obs();
        for (int p = 0; p < 2; p++) begin
            ob_ce_low[p]  = 0;
            ob_oe_low[p]  = 0;
            ob_we_low[p]  = 0;
            ob_ack_cyc[p] = -1;
            ob_err[p]     = 1'b0;
        end
        ob_rdata = 16'h0;
        ob_wdata = 16'h0;
        ob_waddr = 15'h0;
        ack_order.delete();
    endtask

    task automatic check_cycle();
        logic [9:0] act, exp;
        logic [1:0] ce, oe, we, er;
        ce = 2'b11; oe = 2'b11; we = 2'b11; er = 2'b00; exp_ack = 2'b00;
        if (m_busy) begin
            if (!m_miss && m_k <= S + T + H) ce[m_bank] = 1'b0;
            if (!m_miss && m_k > S && m_k <= S + T) begin
                if (m_we) we[m_bank] = 1'b0;
                else      oe[m_bank] = 1'b0;
            end
            if (m_k == m_len) begin
                exp_ack[m_port] = 1'b1;
                er[m_port]      = m_miss;
            end
        end
        exp = {ce[0], ce[1], oe[0], oe[1], we[0], we[1], exp_ack[0], exp_ack[1], er[0], er[1]};
        act = {CE0, CE1, OE0, OE1, WE0, WE1, ack0, ack1, err0, err1};
        chk("strobe_ack_err_vec", 32'(act), 32'(exp));
        if (m_busy && !m_miss && m_k <= S + T + H) begin
            chk("mem_addr", 32'(mem_addr), 32'(m_addr[15:1]));
            if (m_we) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        end
        if (m_busy && m_k == m_len) begin
            if (!m_we && !m_miss) chk("rdata", 32'(rdata), 32'(m_rdata));
            $display("txn cyc=%0d port=%0d %s addr=%h wdata=%h rdata=%h err=%0d",
                     cyc, m_port, m_we ? "WR" : "RD", m_addr, m_wdata, rdata, m_miss);
        end
        if (!CE0) ob_ce_low[0]++;
        if (!CE1) ob_ce_low[1]++;
        if (!OE0) ob_oe_low[0]++;
        if (!OE1) ob_oe_low[1]++;
        if (!WE0) ob_we_low[0]++;
        if (!WE1) ob_we_low[1]++;
        if (!WE0 || !WE1) begin
            ob_waddr = mem_addr;
            ob_wdata = mem_wdata;
        end
        if (ack0) begin
            ob_ack_cyc[0] = cyc; ob_err[0] = err0; ob_rdata = rdata; ack_order.push_back(0);
        end
        if (ack1) begin
            ob_ack_cyc[1] = cyc; ob_err[1] = err1; ob_rdata = rdata; ack_order.push_back(1);
        end
    endtask

    task automatic new_req(input int p);
        logic [15:0] hi, lo;
        hi = 16'h2000;
        lo = 16'($urandom);
        if ($urandom_range(4) == 0) begin
            hi = 16'($urandom);
            if (hi == 16'h2000) hi = 16'h2001;
        end
        req_v[p]   = 1'b1;
        we_v[p]    = 1'($urandom);
        addr_v[p]  = {hi, lo};
        wdata_v[p] = 16'($urandom);
    endtask

    task automatic drive_inputs();
        for (int p = 0; p < 2; p++) begin
            if (exp_ack[p]) begin
                inflight[p] = 1'b0;
                if (dcnt[p] > 0) dcnt[p]--;
            end
            if (rand_mode) begin
                if (exp_ack[p]) begin
                    if (req_v[p]) begin
                        if ($urandom_range(1) == 1) new_req(p);
                        else req_v[p] = 1'b0;
                    end
                end else if (!req_v[p]) begin
                    if (!inflight[p] && $urandom_range(3) == 0) new_req(p);
                    else begin
                        we_v[p] = 1'($urandom); addr_v[p] = $urandom; wdata_v[p] = 16'($urandom);
                    end
                end else if (!(m_busy && m_port == 1'(p)) && $urandom_range(15) == 0) begin
                    req_v[p] = 1'b0;
                end else if (m_busy && m_port == 1'(p) && $urandom_range(31) == 0) begin
                    req_v[p] = 1'b0;
                end
            end else begin
                req_v[p] = (dcnt[p] > 0);
            end
        end
        mem_rdata = rand_mode ? 16'($urandom) : d_rdata;
        reset  = rst_v;
        req0   = req_v[0];  req1   = req_v[1];
        we0    = we_v[0];   we1    = we_v[1];
        addr0  = addr_v[0]; addr1  = addr_v[1];
        wdata0 = wdata_v[0]; wdata1 = wdata_v[1];
    endtask

    task automatic model_advance();
        int p;
        if (rst_v) begin
            m_busy = 1'b0; m_fav = 1'b0; inflight[0] = 1'b0; inflight[1] = 1'b0;
            return;
        end
        if (m_busy) begin
            if (m_k == S + T && !m_miss && !m_we) m_rdata = mem_rdata;
            if (m_k == m_len) m_busy = 1'b0;
            else m_k++;
        end else if (req_v[0] || req_v[1]) begin
            if (req_v[0] && req_v[1]) p = m_fav ? 1 : 0;
            else p = req_v[1] ? 1 : 0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            m_fav = (p == 0);
`endif
            m_busy  = 1'b1;
            m_k     = 1;
            m_port  = 1'(p);
            m_we    = we_v[p];
            m_addr  = addr_v[p];
            m_wdata = wdata_v[p];
            m_miss  = (addr_v[p][31:16] != 16'h2000);
            m_bank  = addr_v[p][15];
            m_len   = m_miss ? 1 : S + T + H + 1;
            inflight[p] = 1'b1;
            t_grant = cyc;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        check_cycle();
        drive_inputs();
        model_advance();
    endtask

    task automatic set_dir(input int p, input logic we, input logic [31:0] a,
                           input logic [15:0] wd, input int n);
        we_v[p] = we; addr_v[p] = a; wdata_v[p] = wd; dcnt[p] = n;
    endtask

    task automatic run_until_idle(input string name);
        int guard;
        guard = 0;
        do begin
            step();
            guard++;
        end while ((dcnt[0] > 0 || dcnt[1] > 0 || m_busy) && guard < 300);
        if (guard >= 300) begin
            total++; bad++;
            $display("FAIL %s_timeout: got %0d cycles want <300", name, guard);
        end
        step();
        step();
    endtask

    int exp_order[4];
    int lat, nce, noe, ce_cyc, oe_cyc, nack;
    logic [15:0] frd;

    initial begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        reset = 1'b1; rst_v = 1'b1; rand_mode = 1'b0; d_rdata = 16'h0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        mem_rdata = 16'h0;
        f_req0 = 0; f_we0 = 0; f_addr0 = 0; f_mem_rdata = 16'hA5C3;
        m_busy = 0; m_fav = 0; m_k = 0; m_len = 0; m_port = 0; m_we = 0; m_miss = 0; m_bank = 0;
        m_addr = 0; m_wdata = 0; m_rdata = 0; exp_ack = 0; t_grant = 0;
        for (int p = 0; p < 2; p++) begin
            req_v[p] = 0; we_v[p] = 0; addr_v[p] = 0; wdata_v[p] = 0; inflight[p] = 0; dcnt[p] = 0;
        end
        clear_obs();

        repeat (3) step();
        chk("reset_strobes", 32'({CE0, CE1, OE0, OE1, WE0, WE1}), 32'h3F);
        chk("reset_ack_err", 32'({ack0, ack1, err0, err1}), 32'h0);
        chk("reset_rdata", 32'(rdata), 32'h0);
        chk("reset_mem_addr", 32'(mem_addr), 32'h0);
        chk("reset_mem_wdata", 32'(mem_wdata), 32'h0);
        rst_v = 1'b0;
        step();

        // Port 0 read of a bank-0 hit.
        clear_obs(); d_rdata = 16'hBEEF;
        set_dir(0, 1'b0, 32'h2000_0010, 16'h0, 1);
        run_until_idle("rd0");
        chk("rd0_ce0_low", 32'(ob_ce_low[0]), 4);
        chk("rd0_oe0_low", 32'(ob_oe_low[0]), 2);
        chk("rd0_ce1_we_low", 32'(ob_ce_low[1] + ob_we_low[0] + ob_we_low[1] + ob_oe_low[1]), 0);
        chk("rd0_latency", 32'(ob_ack_cyc[0] - t_grant), 5);
        chk("rd0_rdata", 32'(ob_rdata), 32'hBEEF);
        chk("rd0_err", 32'(ob_err[0]), 0);

        // Out-of-window access.
        clear_obs();
        set_dir(0, 1'b0, 32'h3000_0000, 16'h0, 1);
        run_until_idle("miss0");
        chk("miss0_latency", 32'(ob_ack_cyc[0] - t_grant), 1);
        chk("miss0_err", 32'(ob_err[0]), 1);
        chk("miss0_no_strobes", 32'(ob_ce_low[0] + ob_ce_low[1] + ob_oe_low[0] + ob_oe_low[1]
                                    + ob_we_low[0] + ob_we_low[1]), 0);

        // Port 1 write to bank 1.
        clear_obs();
        set_dir(1, 1'b1, 32'h2000_8002, 16'h1234, 1);
        run_until_idle("wr1");
        chk("wr1_ce1_low", 32'(ob_ce_low[1]), 4);
        chk("wr1_we1_low", 32'(ob_we_low[1]), 2);
        chk("wr1_oe1_ce0_low", 32'(ob_oe_low[1] + ob_ce_low[0]), 0);
        chk("wr1_mem_addr", 32'(ob_waddr), 32'h4001);
        chk("wr1_mem_wdata", 32'(ob_wdata), 32'h1234);
        chk("wr1_err", 32'(ob_err[1]), 0);
        chk("wr1_latency", 32'(ob_ack_cyc[1] - t_grant), 5);

        // Both ports requesting continuously.
        clear_obs(); d_rdata = 16'h5A5A;
        set_dir(0, 1'b0, 32'h2000_0200, 16'h0, 4);
        set_dir(1, 1'b0, 32'h2000_8200, 16'h0, 4);
        run_until_idle("alt");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("alt_grant%0d", i),
                32'((i < ack_order.size()) ? ack_order[i] : 99), 32'(exp_order[i]));
        end

        // Reset pulsed during the STROBE phase of a read.
        clear_obs(); d_rdata = 16'hCAFE;
        set_dir(0, 1'b0, 32'h2000_0100, 16'h0, 1);
        for (int g = 0; g < 20 && !(m_busy && m_k == S + 1); g++) step();
        chk("rst_reached_strobe", 32'(m_busy && m_k == S + 1), 1);
        rst_v = 1'b1; dcnt[0] = 0;
        step();
        rst_v = 1'b0;
        step();
        chk("rst_strobes_high", 32'({CE0, CE1, OE0, OE1, WE0, WE1}), 32'h3F);
        chk("rst_no_ack", 32'({ack0, ack1}), 0);
        repeat (6) step();
        chk("rst_ack_suppressed", 32'(ob_ack_cyc[0]), 32'hFFFF_FFFF);
        clear_obs();
        set_dir(0, 1'b0, 32'h2000_0100, 16'h0, 1);
        run_until_idle("post_rst");
        chk("post_rst_latency", 32'(ob_ack_cyc[0] - t_grant), 5);
        chk("post_rst_rdata", 32'(ob_rdata), 32'hCAFE);

        // Random traffic against the model.
        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0;
        dcnt[0] = 0; dcnt[1] = 0;
        run_until_idle("drain");

        // Zero setup/hold, single-cycle strobe instance.
        @(negedge clk);
        f_req0 = 1'b1; f_we0 = 1'b0; f_addr0 = 32'h2000_0040;
        lat = -1; nce = 0; noe = 0; ce_cyc = -1; oe_cyc = -1; nack = 0; frd = 16'h0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (!f_CE0) begin nce++; ce_cyc = j; end
            if (!f_OE0) begin noe++; oe_cyc = j; end
            if (f_ack0) begin
                nack++; lat = j; frd = f_rdata; f_req0 = 1'b0;
                $display("txn fast port=0 RD addr=%h rdata=%h err=%0d", f_addr0, f_rdata, f_err0);
            end
        end
        chk("fast_latency", 32'(lat), 2);
        chk("fast_ce0_low", 32'(nce), 1);
        chk("fast_oe0_low", 32'(noe), 1);
        chk("fast_ce_oe_same_cycle", 32'(ce_cyc), 32'(oe_cyc));
        chk("fast_ack_count", 32'(nack), 1);
        chk("fast_rdata", 32'(frd), 32'hA5C3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
- Shares the two external data SRAM banks between two bus requesters: port 0 is the CPU load/store unit, port 1 is the UART receive-buffer DMA.
- Decodes each request address to a bank and arbitrates between the ports, round-robin by default.
- Sequences the granted access through programmable setup/strobe/hold phases, driving the SRAM CE/OE/WE pins.
- Returns a one-cycle ack with read data, or an error for out-of-window addresses.

Parameters:
- SRAM_BASE_HI, 16'h2000: required value of addr[31:16] for an access to hit SRAM.
- SETUP_CYC, 1: cycles between address/CE assertion and OE/WE assertion; 0 is allowed and skips the SETUP phase.
- STROBE_CYC, 2: cycles OE or WE is held low; must be ≥1.
- HOLD_CYC, 1: cycles CE/address are held after the strobe deasserts; 0 skips the HOLD phase.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0, req1  in  1 each  access request, held high until the matching ack.
- we0, we1  in  1 each  1 = write, 0 = read; stable while req is high.
- addr0, addr1  in  32 each  byte address; stable while req is high.
- wdata0, wdata1  in  16 each  write data; stable while req is high.
- ack0, ack1  out  1 each  one-cycle completion pulse.
- err0, err1  out  1 each  valid only with ack: 1 = address outside the SRAM window.
- rdata  out  16  read data, valid in the ack cycle of a read.
- mem_addr  out  15  word address to the SRAM, taken from addr[15:1].
- mem_wdata  out  16  write data to the SRAM.
- mem_rdata  in  16  read data from the SRAM.
- CE0, CE1, OE0, OE1, WE0, WE1  out  1 each  SRAM bank 0/1 strobes, active low.

Behaviour:
- Reset values: all CE/OE/WE = 1; ack/err = 0; rdata, mem_addr, mem_wdata = 0; FSM = IDLE; round-robin pointer = 0 (port 0 favoured first).
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE. One phase counter, width clog2(max(SETUP_CYC, STROBE_CYC, HOLD_CYC)+1).
- IDLE, one requester high: grant it and latch its we/addr/wdata.
- IDLE, both requesters high: grant the port not granted last, then toggle the pointer.
- Decode at grant:
  - Hit when addr[31:16] == SRAM_BASE_HI; bank = addr[15]; mem_addr = addr[15:1]. addr[0] is ignored.
  - Miss goes directly to DONE with err set; no strobes toggle.
- Hit transitions from IDLE go to SETUP, or to STROBE when SETUP_CYC = 0.
- CE[bank] is driven low from entry to SETUP (or STROBE) through the last HOLD cycle. The other bank's CE stays 1.
- STROBE phase:
  - Read: OE[bank] = 0. Write: WE[bank] = 0 and mem_wdata is driven from the SETUP entry onward.
  - mem_rdata is registered on the last STROBE cycle.
  - OE and WE are never low at the same time, and never low outside STROBE.
- HOLD runs HOLD_CYC cycles with OE/WE = 1; when HOLD_CYC = 0 the FSM goes STROBE → DONE.
- DONE lasts one cycle:
  - ack of the granted port = 1; err as decoded; rdata valid for reads.
  - Then IDLE. IDLE re-arbitrates in that same cycle, so back-to-back requests have 1 idle cycle between accesses.
- Latency with defaults: request sampled in IDLE at cycle N, ack in cycle N+5 (1 + SETUP + STROBE + HOLD). A miss acks at N+1.
- A requester must drop req, or present a new request, in the cycle after ack.
- A request that drops before it is granted is discarded. A request that drops after grant still completes, and its ack is still issued.
- Reset asserted mid-access: at the next edge all strobes return to 1, FSM returns to IDLE, and no ack is issued.

Optional Feature:
- Macro: SRAM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins simultaneous requests and the round-robin pointer is removed. Port 1 can starve; this is intended, for CPU-critical builds.
- Undefined: round-robin arbitration as described above.

Decomposition:
- Package sram_arb_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, HOLD, DONE);
  - the SRAM_BASE_HI default;
  - the bank-select bit index (15);
  - the memory word-address width (15).
- Sub-module rr_arb2 is the natural split:
  - inputs: clk, reset, req[1:0], advance;
  - outputs: one-hot gnt[1:0] plus the pointer;
  - it contains the SRAM_ARB_FIXED_PRIO_EN ifdef.

Test Plan:
- Port 0 read of 32'h2000_0010 with mem_rdata = 16'hBEEF → CE0 low for 4 cycles, OE0 low for 2, CE1/WE* stay 1; ack0 5 cycles later with rdata = 16'hBEEF and err0 = 0.
- Port 1 write of 16'h1234 to 32'h2000_8002 → CE1 low, WE1 low for 2 cycles, mem_addr = 15'h4001, mem_wdata = 16'h1234; ack1 with err1 = 0; OE1 never low.
- req0 and req1 held high together for 4 accesses → grants alternate 0,1,0,1. With SRAM_ARB_FIXED_PRIO_EN defined → grants are 0,0,0,0.
- Port 0 access to 32'h3000_0000 → ack0 and err0 at N+1; all CE/OE/WE remain 1.
- Reset pulsed during the STROBE cycle of a read → next edge: all strobes = 1, FSM in IDLE, no ack0; a fresh request then completes normally.
- SETUP_CYC = 0, HOLD_CYC = 0, STROBE_CYC = 1 → ack at N+2; CE and OE low in the same single cycle.
